// File: rtl/mem_copy_dma.sv
// Memory-to-memory word copier on the single-port memory bus shared with the mips core.
// Each word takes one read cycle and one write cycle. All bus outputs are registered.
module mem_copy_dma #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LENBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   src,
  input  logic [WIDTH-1:0]   dst,
  input  logic [LENBITS-1:0] len,
  output logic               busy,
  output logic               done,
  output logic               memread,
  output logic               memwrite,
  output logic [WIDTH-1:0]   adr,
  output logic [WIDTH-1:0]   writedata,
  input  logic [WIDTH-1:0]   memdata
);

  localparam logic [WIDTH-1:0] WORD_STEP  = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   src_q, src_d;
  logic [WIDTH-1:0]   dst_q, dst_d;
  logic [LENBITS-1:0] len_q, len_d;
  logic [LENBITS-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               memread_q, memread_d;
  logic               memwrite_q, memwrite_d;
  logic [WIDTH-1:0]   adr_q, adr_d;
  logic [WIDTH-1:0]   writedata_q, writedata_d;

  // src_q/dst_q are running word pointers; they advance after every write.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    writedata_d = writedata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src & ALIGN_MASK;
          dst_d   = dst & ALIGN_MASK;
          len_d   = len;
          cnt_d   = '0;
          state_d = (len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        writedata_d = memdata;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = cnt_q + LENBITS'(1);
        src_d   = src_q + WORD_STEP;
        dst_d   = dst_q + WORD_STEP;
        state_d = (cnt_d == len_q) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state once registered.
    busy_d     = (state_d == S_READ) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    memread_d  = (state_d == S_READ);
    memwrite_d = (state_d == S_WRITE);
    adr_d      = '0;
    if (state_d == S_READ) begin
      adr_d = src_d;
    end else if (state_d == S_WRITE) begin
      adr_d = dst_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      adr_q       <= '0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      adr_q       <= adr_d;
      writedata_q <= writedata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign adr       = adr_q;
  assign writedata = writedata_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: 256x32 word memory model, shadow-memory copy model and a
// write scoreboard checked against the bus cycle by cycle.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start;
  logic [31:0] src, dst;
  logic [7:0]  len;
  logic        busy, done, memread, memwrite;
  logic [31:0] adr, writedata, memdata;

  always #5 clk = ~clk;

  mem_copy_dma #(.WIDTH(32), .LENBITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata)
  );

  // Word-addressed memory; the bench loads it through its own port while the DMA is quiet.
  logic [31:0] ram [256];
  logic        tb_we;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;

  assign memdata = ram[adr[9:2]];

  always @(posedge clk) begin
    if (memwrite) ram[adr[9:2]] <= writedata;
    else if (tb_we) ram[tb_wa] <= tb_wd;
  end

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] shadow [256];
  int          total = 0;
  int          bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_eq("rw_excl", 32'(memread & memwrite), 32'd0);
    check_eq("adr_align", 32'(adr[1:0]), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    tb_we = 1'b1;
    tb_wa = 8'(idx);
    tb_wd = val;
    step();
    tb_we = 1'b0;
    shadow[idx] = val;
  endtask

  task automatic mem_check();
    for (int i = 0; i < 64; i++) check_eq($sformatf("ram[%0d]", i), ram[i], shadow[i]);
    check_eq("ram[255]", ram[255], shadow[255]);
  endtask

  // ra: cycle in which reset is raised (-1 none); rs: cycle of an ignored start pulse (-1 none).
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int ra, input int rs);
    logic [31:0] sa, da, a, v;
    logic        aborted, live, exp_done, rd, wr;
    wr_t         e;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      if (ra < 0 || 2 * i + 2 < ra) begin
        a = sa + 32'(4 * i);
        v = shadow[a[9:2]];
        a = da + 32'(4 * i);
        shadow[a[9:2]] = v;
        exp_q.push_back('{adr: a, data: v, cyc: 2 * i + 2});
      end
    end
    src = s;
    dst = d;
    len = 8'(n);
    start = 1'b1;
    step();
    for (int c = 1; c <= 2 * n + 1; c++) begin
      if (c == rs) begin
        start = 1'b1;
        src = 32'h80;
        dst = 32'hC0;
        len = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (c == ra) begin
        reset = 1'b1;
        #1;
      end
      if (c == ra + 2) reset = 1'b0;
      aborted  = (ra > 0) && (c >= ra);
      live     = !aborted && (c <= 2 * n);
      exp_done = !aborted && (c == 2 * n + 1);
      rd       = live && (c % 2 == 1);
      wr       = live && (c % 2 == 0);
      check_eq("busy", 32'(busy), 32'(live));
      check_eq("done", 32'(done), 32'(exp_done));
      check_eq("memread", 32'(memread), 32'(rd));
      check_eq("memwrite", 32'(memwrite), 32'(wr));
      if (rd) check_eq("rd_adr", adr, sa + 32'(4 * ((c - 1) / 2)));
      if (memwrite) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("wr_adr", adr, e.adr);
          check_eq("wr_data", writedata, e.data);
          check_eq("wr_cycle", 32'(c), 32'(e.cyc));
        end
      end
      if (aborted) begin
        check_eq("rst_adr", adr, 32'd0);
        check_eq("rst_wdata", writedata, 32'd0);
      end
      step();
    end
    start = 1'b0;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    start = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    tb_we = 1'b0;
    tb_wa = '0;
    tb_wd = '0;
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_memread", 32'(memread), 32'd0);
    check_eq("rst_memwrite", 32'(memwrite), 32'd0);
    check_eq("rst_adr0", adr, 32'd0);
    check_eq("rst_wdata0", writedata, 32'd0);
    for (int i = 0; i < 64; i++) load(i, 32'hA000_0000 + 32'(i));
    load(255, 32'h5A5A_0FF0);
    reset = 1'b0;
    step();

    // basic copy of four words
    load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
    run_copy(32'd0, 32'd64, 4, -1, -1);
    check_eq("t1_ram16", ram[16], 32'h11);
    check_eq("t1_ram19", ram[19], 32'h44);
    mem_check();

    // zero-length transfer
    run_copy(32'd0, 32'd64, 0, -1, -1);
    mem_check();

    // unaligned addresses are truncated
    load(0, 32'hDEAD_BEEF);
    run_copy(32'd3, 32'h41, 1, -1, -1);
    check_eq("t3_ram16", ram[16], 32'hDEAD_BEEF);
    mem_check();

    // start during a transfer is ignored; start right after done is accepted
    load(0, 32'h0101); load(1, 32'h0202); load(2, 32'h0303); load(3, 32'h0404);
    run_copy(32'd0, 32'h60, 4, -1, 3);
    run_copy(32'h20, 32'h90, 2, -1, -1);
    mem_check();

    // reset in cycle 4 aborts after one word; a fresh copy then works
    load(4, 32'hCAFE_0004); load(5, 32'hCAFE_0005);
    run_copy(32'd0, 32'd128, 4, 4, -1);
    run_copy(32'd16, 32'hA0, 2, -1, -1);
    mem_check();

    // ascending copy over an overlapping region
    load(0, 32'd1); load(1, 32'd2); load(2, 32'd3);
    run_copy(32'd0, 32'd4, 3, -1, -1);
    check_eq("t6_ram1", ram[1], 32'd1);
    check_eq("t6_ram2", ram[2], 32'd1);
    check_eq("t6_ram3", ram[3], 32'd1);
    mem_check();

    // source address wraps past the top of the address space
    run_copy(32'hFFFF_FFFC, 32'hC0, 2, -1, -1);
    check_eq("wrap_ram48", ram[48], 32'h5A5A_0FF0);
    mem_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
